seq_multiplier_nb: RTL and testbench

Parametrised, sequential shift-and-add multiplier. It is the next generation of the 4-bit combinational array multiplier. It trades the adder array for a single WIDTH-bit adder iterated over WIDTH cycles, adds a signed (two's-complement) mode and uses a start/done handshake. It sits in the datapath wherever a full-width product is needed and multi-cycle latency is acceptable.

---
 rtl/seq_multiplier_nb.sv | 125 ++++++++++++
 tb/tb_seq_multiplier_nb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_nb.sv
// Sequential shift-and-add multiplier: one WIDTH-bit add per clock, WIDTH clocks per product,
// optional two's-complement operands handled as sign-magnitude around an unsigned core.
module seq_multiplier_nb #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   resultado
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2*WIDTH-1:0]    res_q, res_d;

    logic [WIDTH-1:0]      addend;
    logic [WIDTH:0]        sum;
    logic [2*WIDTH-1:0]    acc_shifted;
    logic                  unused_acc_lsb;

    // |v| for a two's-complement value; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        magnitude = (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        apply_sign = neg ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    assign unused_acc_lsb = acc_q[0];

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;

        addend      = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Carry lands in the MSB after the right shift; the accumulator LSB falls off.
        acc_shifted = {sum, acc_q[WIDTH-1:1]};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = magnitude(A, signed_mode);
                    mplier_d = magnitude(B, signed_mode);
                    neg_d    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_shifted;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    res_d   = apply_sign(acc_shifted, neg_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = res_q;

endmodule

// File: tb/tb_seq_multiplier_nb.sv
// Directed bench for seq_multiplier_nb: exhaustive unsigned WIDTH=4 plus table-driven and
// hand-written multi-cycle sequences at WIDTH=8.
module tb_seq_multiplier_nb;

    logic        clk;
    logic        reset_L;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  A4, B4;
    logic [7:0]  res4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  A8, B8;
    logic [15:0] res8;

    int nchk;
    int nerr;
    logic [15:0] last8;

    seq_multiplier_nb #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset_L(reset_L), .start(start4), .A(A4), .B(B4),
        .signed_mode(sm4), .busy(busy4), .done(done4), .resultado(res4)
    );

    seq_multiplier_nb #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_L(reset_L), .start(start8), .A(A8), .B(B8),
        .signed_mode(sm8), .busy(busy8), .done(done8), .resultado(res8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge on which done is seen.
    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        int cyc;
        A4 = a; B4 = b; sm4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0;
        chk($sformatf("w4 busy %0d*%0d", a, b), busy4, 1);
        while (!done4 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("w4 latency %0d*%0d", a, b), cyc, 4);
        chk($sformatf("w4 product %0d*%0d", a, b), res4, exp);
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp, input string nm);
        int cyc;
        A8 = a; B8 = b; sm8 = sm; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        chk({nm, " busy"}, busy8, 1);
        chk({nm, " hold"}, res8, last8);
        while (!done8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, cyc, 8);
        chk({nm, " product"}, res8, exp);
        chk({nm, " busy at done"}, busy8, 0);
        last8 = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ndone, overlap, c1, c2;
        logic [15:0] r1, r2;

        nchk = 0; nerr = 0; last8 = '0;
        reset_L = 1'b0;
        start4 = 0; sm4 = 0; A4 = '0; B4 = '0;
        start8 = 0; sm8 = 0; A8 = '0; B8 = '0;

        vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[3] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[5] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
        vecs[6] = '{8'hC8, 8'h03, 1'b0, 16'h0258};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[8] = '{8'hFB, 8'h00, 1'b1, 16'h0000};

        repeat (3) @(negedge clk);
        chk("reset busy8", busy8, 0);
        chk("reset done8", done8, 0);
        chk("reset res8", res8, 0);
        chk("reset busy4", busy4, 0);
        chk("reset res4", res4, 0);
        reset_L = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                mul4(a[3:0], b[3:0], 8'(a * b));

        for (int i = 0; i < 9; i++) begin
            mul8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d done pulse width", i), done8, 0);
        end

        // start held high; A changes mid-run and must only affect the next accepted op
        A8 = 8'd3; B8 = 8'd7; sm8 = 1'b0; start8 = 1'b1;
        ndone = 0; overlap = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 2) A8 = 8'd9;
            if (busy8 && done8) overlap++;
            if (done8) begin
                ndone++;
                if (ndone == 1) begin c1 = cyc; r1 = res8; end
                if (ndone == 2) begin c2 = cyc; r2 = res8; end
            end
        end
        start8 = 1'b0;
        repeat (10) @(negedge clk);
        chk("held first done cycle", c1, 8);
        chk("held second done cycle", c2, 17);
        chk("held first result 3*7", r1, 21);
        chk("held second result 9*7", r2, 63);
        chk("held done count", ndone, 3);
        chk("held busy/done overlap", overlap, 0);
        last8 = 16'd63;

        // asynchronous reset in the middle of a run
        A8 = 8'd100; B8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", busy8, 1);
        chk("pre-reset res", res8, 63);
        #2 reset_L = 1'b0;
        #1;
        chk("async reset busy", busy8, 0);
        chk("async reset res", res8, 0);
        chk("async reset done", done8, 0);
        @(negedge clk);
        reset_L = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("no done after reset", ndone, 0);
        chk("res after aborted op", res8, 0);
        last8 = '0;
        mul8(8'd6, 8'd7, 1'b0, 16'd42, "after reset 6*7");

        // back-to-back: second start issued in the done cycle of the first
        mul8(8'd12, 8'd10, 1'b0, 16'd120, "b2b 12*10");
        mul8(8'd5, 8'd5, 1'b0, 16'd25, "b2b 5*5");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d res", i), res8, 25);
            chk($sformatf("idle%0d busy", i), busy8, 0);
            chk($sformatf("idle%0d done", i), done8, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
